// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS receive checker.
// Hunts (fills its shift register from the line), verifies self-synchronously,
// then flywheels on its own prediction and counts bit errors while locked.
// Too many errors inside one window drop it back to hunting.
// Optional macro PRBS_CHK_BITCNT_EN adds a 32-bit count of bits checked in LOCKED.
module prbs_checker #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'b1000000001011,
  parameter bit              INVERT      = 1'b0,
  parameter int              LOCK_COUNT  = 32,
  parameter int              WINDOW      = 64,
  parameter int              LOSS_THRESH = 8,
  parameter int              ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EWIN_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   s, s_nxt;
  logic [FILL_W-1:0]  fill_cnt, fill_cnt_nxt;
  logic [MATCH_W-1:0] match_cnt, match_cnt_nxt;
  logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [EWIN_W-1:0]  err_win, err_win_nxt;
  logic [ERR_W-1:0]   err_count_nxt;
  logic               err_pulse_nxt;

  logic               p, match, degen;
  logic [WIDTH-1:0]   s_in, s_fly;
  logic [FILL_W-1:0]  fill_inc;
  logic [MATCH_W-1:0] match_inc;
  logic [EWIN_W-1:0]  ewin_inc;

  // Prediction is the generator's next feedback bit computed from our copy of its state.
  assign p         = (^(s & TAPS)) ^ INVERT;
  assign match     = (in_bit == p);
  assign s_in      = {in_bit, s[WIDTH-1:1]};
  assign s_fly     = {p, s[WIDTH-1:1]};
  // A stuck line fills s with the LFSR's lock-up value, which trivially "matches" forever.
  assign degen     = INVERT ? (&s_in) : ~(|s_in);
  assign fill_inc  = fill_cnt + FILL_W'(1);
  assign match_inc = match_cnt + MATCH_W'(1);
  assign ewin_inc  = err_win + EWIN_W'(!match);

  // Next-state and counter updates for the hunt / sync / flywheel states.
  always_comb begin
    state_nxt     = state;
    s_nxt         = s;
    fill_cnt_nxt  = fill_cnt;
    match_cnt_nxt = match_cnt;
    win_cnt_nxt   = win_cnt;
    err_win_nxt   = err_win;
    err_count_nxt = err_count;
    err_pulse_nxt = 1'b0;
    if (enable) begin
      unique case (state)
        HUNT: begin
          s_nxt = s_in;
          if (fill_inc == FILL_W'(WIDTH)) begin
            state_nxt     = SYNC;
            fill_cnt_nxt  = '0;
            match_cnt_nxt = '0;
          end else begin
            fill_cnt_nxt = fill_inc;
          end
        end
        SYNC: begin
          s_nxt = s_in;
          if (!match || degen) begin
            match_cnt_nxt = '0;
          end else if (match_inc == MATCH_W'(LOCK_COUNT)) begin
            state_nxt     = LOCKED;
            match_cnt_nxt = match_inc;
            win_cnt_nxt   = '0;
            err_win_nxt   = '0;
          end else begin
            match_cnt_nxt = match_inc;
          end
        end
        LOCKED: begin
          // Shift in the prediction, not the line bit, so one line error counts once.
          s_nxt         = s_fly;
          err_pulse_nxt = !match;
          if (!match && (err_count != {ERR_W{1'b1}}))
            err_count_nxt = err_count + ERR_W'(1);
          if (ewin_inc == EWIN_W'(LOSS_THRESH)) begin
            state_nxt    = HUNT;
            fill_cnt_nxt = '0;
            win_cnt_nxt  = '0;
            err_win_nxt  = '0;
          end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
            win_cnt_nxt = '0;
            err_win_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + WIN_W'(1);
            err_win_nxt = ewin_inc;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    if (clear_cnt)
      err_count_nxt = '0;
  end

  // State register and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      s         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      err_win   <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      fill_cnt  <= fill_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      win_cnt   <= win_cnt_nxt;
      err_win   <= err_win_nxt;
      err_count <= err_count_nxt;
      err_pulse <= err_pulse_nxt;
      locked    <= (state_nxt == LOCKED);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  // Bits checked while locked; survives loss of lock so it pairs with err_count for BER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bit_count <= '0;
    else if (clear_cnt)
      bit_count <= '0;
    else if (enable && (state == LOCKED) && (bit_count != 32'hFFFF_FFFF))
      bit_count <= bit_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table of error-injection scenarios with fixed
// expected results, hand sequences for the corner cases, and a randomized
// run compared cycle by cycle against a bit-history reference model.
module tb_prbs_checker;
  localparam int          WIDTH = 16;
  localparam logic [15:0] TAPS  = 16'b1000000001011;
  localparam int          LOCKN = 32;
  localparam int          WIN   = 64;
  localparam int          LOSS  = 8;
  localparam int          ERRW  = 16;

  logic        clk = 1'b0;
  logic        reset, enable, in_bit, clear_cnt;
  logic        locked, err_pulse, locked3, err_pulse3;
  logic [15:0] err_count;
  logic [2:0]  err_count3;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count3;
`endif

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  prbs_checker #(.ERR_W(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .clear_cnt(clear_cnt),
    .locked(locked3), .err_pulse(err_pulse3), .err_count(err_count3)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count3)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] gen;

  // reference model: history of bits the checker has taken in, newest at index 0
  int  m_mode;   // 0 hunt, 1 sync, 2 locked
  bit  hist[$];
  int  m_fill, m_run, m_lbits, m_werr, m_cnt;
  bit  m_pulse, m_locked;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit gen_bit();
    logic [15:0] t;
    bit fb;
    t = TAPS;
    fb = ^(gen & t);
    gen = {fb, gen[15:1]};
    return fb;
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < WIDTH; i++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_lbits = 0; m_werr = 0;
    m_cnt = 0; m_pulse = 0; m_locked = 0;
  endtask

  function automatic bit model_pred();
    logic [15:0] t;
    bit pr;
    t = TAPS;
    pr = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (t[i]) pr ^= hist[WIDTH-1-i];
    return pr;
  endfunction

  task automatic push_bit(input bit b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_step(input bit en, input bit b, input bit clr);
    bit pr, allz;
    m_pulse = 0;
    if (en) begin
      pr = model_pred();
      if (m_mode == 0) begin
        push_bit(b);
        m_fill++;
        if (m_fill == WIDTH) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        push_bit(b);
        m_run = (b == pr) ? m_run + 1 : 0;
        allz = 1;
        foreach (hist[i]) if (hist[i]) allz = 0;
        if (allz) m_run = 0;
        if (m_run == LOCKN) begin m_mode = 2; m_lbits = 0; m_werr = 0; end
      end else begin
        push_bit(pr);
        if (b != pr) begin
          m_pulse = 1;
          m_werr++;
          if (m_cnt < (1 << ERRW) - 1) m_cnt++;
        end
        if (m_werr == LOSS) begin
          m_mode = 0; m_fill = 0;
        end else begin
          m_lbits++;
          if (m_lbits % WIN == 0) m_werr = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input bit en, input bit b, input bit clr);
    enable = en; in_bit = b; clear_cnt = clr;
    @(posedge clk);
    model_step(en, b, clr);
    #1;
    check("locked", locked, m_locked);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, m_cnt);
  endtask

  task automatic send(input bit flip, input bit clr);
    bit g;
    g = gen_bit();
    step(1'b1, g ^ flip, clr);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
    gen = 16'h0001;
    model_reset();
    @(posedge clk); #1;
    check("rst locked", locked, 0);
    check("rst err_pulse", err_pulse, 0);
    check("rst err_count", err_count, 0);
    check("rst err_count3", err_count3, 0);
    reset = 1'b1;
  endtask

  // reset, 47 clean bits unlocked, 48th brings lock
  task automatic get_lock();
    do_reset();
    clean(47);
    check("prelock", locked, 0);
    send(1'b0, 1'b0);
    check("lock48", locked, 1);
  endtask

  typedef struct {
    int n_err;
    int start;
    int spacing;
    bit exp_locked;
    int exp_cnt;
  } scen_t;

  scen_t tbl[7];

  initial begin
    int nvalid, cyc, seen, rate, k_end;
    bit flip, en;

    // error positions are counted in valid bits since lock (windows start at 0)
    tbl[0] = '{1,  10, 1, 1'b1, 1};   // single error
    tbl[1] = '{8,  0,  1, 1'b0, 8};   // burst of 8
    tbl[2] = '{7,  0,  9, 1'b1, 7};   // 7 in one window
    tbl[3] = '{14, 1,  9, 1'b1, 14};  // 7 in window 0 + 7 in window 1
    tbl[4] = '{8,  0,  8, 1'b0, 8};   // 8 spread over one window
    tbl[5] = '{8,  60, 1, 1'b1, 8};   // straddles a window boundary
    tbl[6] = '{8,  56, 1, 1'b0, 8};   // 8th error on last bit of a window

    for (int t = 0; t < 7; t++) begin
      get_lock();
      k_end = tbl[t].start + (tbl[t].n_err - 1) * tbl[t].spacing;
      for (int k = 0; k <= k_end; k++) begin
        flip = (k >= tbl[t].start) && ((k - tbl[t].start) % tbl[t].spacing == 0) &&
               ((k - tbl[t].start) / tbl[t].spacing < tbl[t].n_err);
        send(flip, 1'b0);
      end
      check($sformatf("scen%0d locked", t), locked, tbl[t].exp_locked);
      check($sformatf("scen%0d count", t), err_count, tbl[t].exp_cnt);
      clean(5);
      check($sformatf("scen%0d locked+5", t), locked, tbl[t].exp_locked);
    end

    // relock after a burst needs 48 clean bits
    get_lock();
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
    check("burst unlocked", locked, 0);
    clean(47);
    check("relock 47", locked, 0);
    send(1'b0, 1'b0);
    check("relock 48", locked, 1);
    check("burst count held", err_count, 8);

    // long clean stream
    get_lock();
    clean(1000);
    check("clean locked", locked, 1);
    check("clean count", err_count, 0);

    // all-zero line never locks
    do_reset();
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) seen++;
    end
    check("zeros lock seen", seen, 0);
    check("zeros count", err_count, 0);

    // clear coincident with an error wins, pulse still fires
    get_lock();
    clean(5);
    send(1'b1, 1'b0);
    check("pre-clear count", err_count, 1);
    clean(3);
    send(1'b1, 1'b1);
    check("clear count", err_count, 0);
    check("clear pulse", err_pulse, 1);

    // async reset mid-lock, checked before any clock edge
    get_lock();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("async locked", locked, 0);
    check("async pulse", err_pulse, 0);
    check("async count", err_count, 0);
    model_reset();
    #2;
    reset = 1'b1;
    clean(47);
    check("post-rst 47", locked, 0);
    send(1'b0, 1'b0);
    check("post-rst 48", locked, 1);

    // saturation on the ERR_W=3 instance: one error per window
    get_lock();
    for (int j = 0; j < 10; j++) begin
      clean(5);
      send(1'b1, 1'b0);
      clean(58);
    end
    check("sat count3", err_count3, 7);
    check("sat count16", err_count, 10);
    check("sat locked3", locked3, 1);

    // random enable gaps: lock after exactly 48 valid bits
    do_reset();
    nvalid = 0; cyc = 0;
    while (!m_locked && cyc < 400) begin
      en = ($urandom % 2) == 1;
      if (en) begin
        nvalid++;
        send(1'b0, 1'b0);
      end else begin
        step(1'b0, 1'($urandom % 2), 1'b0);
      end
      cyc++;
    end
    check("gap lock bits", nvalid, 48);
    check("gap locked", locked, 1);

    // random gaps, errors and clears against the model
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 500) % 2 == 1) ? 10 : 60;
      en = ($urandom % 2) == 1;
      if (en) send(1'(($urandom % rate) == 0), 1'(($urandom % 150) == 0));
      else    step(1'b0, 1'($urandom % 2), 1'(($urandom % 150) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
